rx_frame_fsm: RTL and testbench
===============================

// Module: rx_frame_fsm
// PURPOSE
//  Receive-side companion to the table transmit FSM: consumes bytes from the UART receiver and
//  assembles a 4-byte frame {SYNC, DATA_HI, DATA_LO, CHK}. Acknowledges each byte to the receiver.
//  Checks CHK = DATA_HI ^ DATA_LO. Publishes a 16-bit word with a one-cycle valid strobe.
//  Sits between the UART receiver and the security-system command decoder.
// PARAMETERS
//  SYNC     8'hA5  frame start byte; non-matching bytes in the hunt phase are discarded
//  TIMEOUT  1000   max clk cycles spent waiting for a byte mid-frame before aborting (>=2)
// PORTS
//  clk         in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-high reset
//  rxready     in   1   receiver holds a byte in rxdata; stays high until acknowledged
//  rxdata      in   8   received byte, valid while rxready=1
//  rdrxdata    out  1   one-cycle pulse: byte consumed, receiver clears rxready
//  frame       out  16  last good payload {DATA_HI,DATA_LO}; updated only on a good frame
//  frame_valid out  1   one-cycle pulse, coincident with frame update
//  frame_err   out  1   one-cycle pulse on checksum mismatch or mid-frame timeout
// BEHAVIOUR
//  Reset (async, any state): state=WAIT, idx=0, timer=0, byte regs=0,
//   frame=16'h0000, rdrxdata=0, frame_valid=0, frame_err=0.
//  idx (2b): 0=SYNC, 1=HI, 2=LO, 3=CHK. States WAIT, ACK, DRAIN, EVAL.
//   All outputs are registered or Moore outputs; there is no combinational path from rxready.
//  WAIT:  if rxready=1 at the edge, latch rxdata into the idx slot and go to ACK.
//  ACK:   rdrxdata=1 for exactly this cycle, then go to DRAIN.
//  DRAIN: wait for rxready=0, then:
//   - idx=0 and latched byte!=SYNC: idx stays 0, go to WAIT (silent discard, no error).
//   - idx=3: go to EVAL.
//   - otherwise: idx+1, go to WAIT.
//  EVAL (one cycle), then WAIT with idx=0:
//   - CHK==HI^LO: frame<={HI,LO} and frame_valid=1 during EVAL.
//   - otherwise: frame_err=1 during EVAL and frame holds its value.
//  Timeout: timer clears on every entry to WAIT.
//   - It increments in WAIT and DRAIN while idx!=0.
//   - When timer reaches TIMEOUT-1: frame_err=1 for one cycle, idx=0, state=WAIT.
//   - Any partial frame is discarded. The hunt phase (idx=0) never times out.
//  Latency: rxready rises, then ACK one cycle later.
//   From the CHK byte's rxready falling, EVAL (valid/err) follows one cycle later.
//  rxready held high through DRAIN: no extra rdrxdata; exactly one ack per byte.
//  A SYNC value seen at idx 1..3 is treated as data (no resync).
//  frame_valid and frame_err are never high in the same cycle.
// TESTING
//  1. Send A5,12,34,26 (rxready drops 1 cycle after each rdrxdata):
//     frame=16'h1234, frame_valid one pulse, frame_err never, 4 rdrxdata pulses.
//  2. Send A5,12,34,27: frame_err one pulse, frame unchanged (16'h0000 after reset), no frame_valid.
//  3. Send 00,FF,A5,AB,CD,66: 00 and FF are acked and discarded; frame=16'hABCD, frame_valid one pulse.
//  4. Send A5,12, then idle TIMEOUT cycles: frame_err one pulse, idx back to 0.
//     A following A5,56,78,2E gives frame=16'h5678 and frame_valid.
//  5. Send A5,12, then assert reset for 2 cycles: all outputs 0 and state WAIT.
//     A following A5,9A,BC,26 gives frame=16'h9ABC.
//  6. Hold rxready high 20 cycles on one byte: exactly one rdrxdata pulse.
//     The frame still completes after rxready drops.

Source files
------------

// File: rtl/rx_frame_fsm.sv
// Receive-side frame assembler: collects {SYNC, HI, LO, CHK} from a UART receiver,
// acknowledges each byte once, and publishes the 16-bit payload when the checksum holds.
module rx_frame_fsm #(
   parameter logic [7:0] SYNC    = 8'hA5,
   parameter int          TIMEOUT = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rxready,
   input  logic [7:0]  rxdata,
   output logic        rdrxdata,
   output logic [15:0] frame,
   output logic        frame_valid,
   output logic        frame_err
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {WAIT, ACK, DRAIN, EVAL} state_t;

   state_t          state, state_nx;
   logic [1:0]      idx, idx_nx;
   logic [TW-1:0]   timer, timer_nx;
   logic [3:0][7:0] byt, byt_nx;
   logic [15:0]     frame_nx;
   logic            valid_nx, err_nx;
   logic            timed_out;

   // the hunt phase (idx 0) never times out
   assign timed_out = (idx != 2'd0) && ((state == WAIT) || (state == DRAIN)) &&
                      (timer == TW'(TIMEOUT - 1));

   assign rdrxdata = (state == ACK);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= WAIT;
         idx         <= 2'd0;
         timer       <= '0;
         byt         <= '0;
         frame       <= 16'h0000;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state       <= state_nx;
         idx         <= idx_nx;
         timer       <= timer_nx;
         byt         <= byt_nx;
         frame       <= frame_nx;
         frame_valid <= valid_nx;
         frame_err   <= err_nx;
      end
   end

   // valid/err are registered on the edge entering EVAL so they are high during EVAL
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      timer_nx = timer;
      byt_nx   = byt;
      frame_nx = frame;
      valid_nx = 1'b0;
      err_nx   = 1'b0;
      case (state)
         WAIT: begin
            if (timed_out) begin
               err_nx   = 1'b1;
               idx_nx   = 2'd0;
               timer_nx = '0;
            end else begin
               if (idx != 2'd0) timer_nx = timer + 1'b1;
               if (rxready) begin
                  byt_nx[idx] = rxdata;
                  state_nx    = ACK;
               end
            end
         end
         ACK: state_nx = DRAIN;
         DRAIN: begin
            if (timed_out) begin
               err_nx   = 1'b1;
               idx_nx   = 2'd0;
               timer_nx = '0;
               state_nx = WAIT;
            end else if (!rxready) begin
               if (idx == 2'd3) begin
                  state_nx = EVAL;
                  if (byt[3] == (byt[1] ^ byt[2])) begin
                     frame_nx = {byt[1], byt[2]};
                     valid_nx = 1'b1;
                  end else begin
                     err_nx = 1'b1;
                  end
               end else begin
                  state_nx = WAIT;
                  timer_nx = '0;
                  if (!(idx == 2'd0 && byt[0] != SYNC)) idx_nx = idx + 2'd1;
               end
            end else if (idx != 2'd0) begin
               timer_nx = timer + 1'b1;
            end
         end
         EVAL: begin
            state_nx = WAIT;
            idx_nx   = 2'd0;
            timer_nx = '0;
         end
         default: state_nx = WAIT;
      endcase
   end

endmodule

// File: tb/tb_rx_frame_fsm.sv
// Scoreboard bench for rx_frame_fsm: frame outcomes are queued when the CHK byte is
// driven and compared when frame_valid/frame_err pulses.
module tb_rx_frame_fsm;

   localparam int TO = 40;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rxready = 1'b0;
   logic [7:0]  rxdata = 8'h00;
   logic        rdrxdata;
   logic [15:0] frame;
   logic        frame_valid;
   logic        frame_err;

   rx_frame_fsm #(.SYNC(8'hA5), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .rxready(rxready), .rxdata(rxdata),
      .rdrxdata(rdrxdata), .frame(frame), .frame_valid(frame_valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic err; logic [15:0] frame;} exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          acks = 0;
   logic [15:0] good = 16'h0000;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (rdrxdata) acks++;
      if (frame_valid || frame_err) begin
         chk("excl", {31'b0, frame_valid & frame_err}, 32'd0);
         if (sb.size() == 0) begin
            chk("unexp_out", {30'b0, frame_err, frame_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("kind", {31'b0, frame_err}, {31'b0, e.err});
            chk("frame", {16'b0, frame}, {16'b0, e.frame});
         end
      end
   end

   task automatic send(input logic [7:0] b, input int hold);
      int n;
      @(posedge clk); #1 rxready = 1'b1; rxdata = b;
      n = 0;
      @(negedge clk);
      while (!rdrxdata && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!rdrxdata) chk("ack_timeout", {31'b0, rdrxdata}, 32'd1);
      repeat (hold) @(posedge clk);
      @(posedge clk); #1 rxready = 1'b0;
   endtask

   task automatic frame4(input logic [7:0] s, input logic [7:0] hi, input logic [7:0] lo,
                         input logic [7:0] ck, input int hold_hi);
      exp_t e;
      send(s, 0);
      send(hi, hold_hi);
      send(lo, 0);
      if (ck == (hi ^ lo)) begin
         good = {hi, lo};
         e.err = 1'b0;
      end else begin
         e.err = 1'b1;
      end
      e.frame = good;
      sb.push_back(e);
      send(ck, 0);
      repeat (4) @(posedge clk);
   endtask

   task automatic chk_idle(input string tag);
      @(negedge clk);
      chk({tag, "_ack"}, {31'b0, rdrxdata}, 32'd0);
      chk({tag, "_val"}, {31'b0, frame_valid}, 32'd0);
      chk({tag, "_err"}, {31'b0, frame_err}, 32'd0);
      chk({tag, "_frame"}, {16'b0, frame}, 32'd0);
   endtask

   initial begin
      int a0;
      int n;
      exp_t e;
      repeat (2) @(posedge clk);
      chk_idle("rst");
      @(posedge clk); #1 reset = 1'b0;

      // bad checksum: frame stays 0
      a0 = acks;
      frame4(8'hA5, 8'h12, 8'h34, 8'h27, 0);
      chk("acks_bad", acks - a0, 32'd4);

      // good frame
      a0 = acks;
      frame4(8'hA5, 8'h12, 8'h34, 8'h26, 0);
      chk("acks_good", acks - a0, 32'd4);

      // junk bytes before sync are acked and dropped
      a0 = acks;
      send(8'h00, 0);
      send(8'hFF, 0);
      frame4(8'hA5, 8'hAB, 8'hCD, 8'h66, 0);
      chk("acks_hunt", acks - a0, 32'd6);

      // mid-frame timeout
      send(8'hA5, 0);
      send(8'h12, 0);
      e.err = 1'b1;
      e.frame = good;
      sb.push_back(e);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_err && n < TO + 20);
      chk("to_lat_ok", {31'b0, (n >= TO && n <= TO + 3)}, 32'd1);
      repeat (3) @(posedge clk);
      frame4(8'hA5, 8'h56, 8'h78, 8'h2E, 0);

      // reset mid-frame
      send(8'hA5, 0);
      send(8'h12, 0);
      @(posedge clk); #1 reset = 1'b1;
      good = 16'h0000;
      repeat (2) @(posedge clk);
      chk_idle("rst2");
      @(posedge clk); #1 reset = 1'b0;
      frame4(8'hA5, 8'h9A, 8'hBC, 8'h26, 0);

      // rxready held high on one byte: one ack only
      a0 = acks;
      frame4(8'hA5, 8'h3C, 8'hC3, 8'hFF, 20);
      chk("acks_hold", acks - a0, 32'd4);

      repeat (5) @(posedge clk);
      chk("sb_drain", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=%0d exp=%0d", n_chk, 0);
      $fatal(1, "bench timed out");
   end

endmodule
